// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU (ADD/AND/NOT/SHIFT) with valid/ready handshakes and nzp codes; ports clk,rst,in_valid/in_ready,opcode,a,b,ld_cc -> out_valid/out_ready,out,err,nzp
module alu_seq #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ld_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             err,
  output logic [2:0]       nzp
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx, res;
  logic [SHW-1:0] cnt;
  logic dir, ari, ld, accept, take, is_sh, multi, bad;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign take = out_valid && out_ready;
  assign is_sh = opcode == 4'b1101;
  assign multi = is_sh && b[SHW-1:0] != '0;
  assign bad = !(opcode inside {4'b0001, 4'b0101, 4'b1001, 4'b1101});
  always_comb begin
    res = opcode == 4'b0001 ? a + b : opcode == 4'b0101 ? a & b : opcode == 4'b1001 ? ~a : is_sh ? a : '0;
    sh_nx = dir ? {ari & sh[WIDTH-1], sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};
  end
  always_comb begin
    state_nx = state == IDLE ? (accept ? (multi ? SHIFT : DONE) : IDLE)
             : state == SHIFT ? (cnt == SHW'(1) ? DONE : SHIFT)
             : (take ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      err <= 1'b0;
      nzp <= 3'b010;
      cnt <= '0;
      sh <= '0;
      dir <= 1'b0;
      ari <= 1'b0;
      ld <= 1'b0;
    end else begin
      if (accept) begin
        sh <= a;
        cnt <= b[SHW-1:0];
        dir <= b[SHW];
        ari <= b[SHW+1];
        ld <= ld_cc;
        if (!multi) begin
          out <= res;
          err <= bad;
        end
      end
      if (state == SHIFT) begin
        sh <= sh_nx;
        cnt <= cnt - 1'b1;
        if (cnt == SHW'(1)) begin
          out <= sh_nx;
          err <= 1'b0;
        end
      end
      if (take && ld && !err) nzp <= out[WIDTH-1] ? 3'b100 : out == '0 ? 3'b010 : 3'b001;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;
  localparam int W = 16;
  logic clk = 1'b0, rst, in_valid, ld_cc, out_ready;
  logic [3:0] opcode;
  logic [W-1:0] a, b;
  logic in_ready, out_valid, err;
  logic [W-1:0] out;
  logic [2:0] nzp;
  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b), .ld_cc(ld_cc), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .err(err), .nzp(nzp)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [2:0] exp_nzp;
  logic [W-1:0] prev_out;
  logic prev_err;
  int r_lat;
  bit r_tmo, r_stable, r_ir_low, r_hold, r_post_ir, r_post_ov, r_acc_ok;
  logic [W-1:0] r_out;
  logic r_err;
  logic [2:0] r_nzp_pre, r_nzp_post;
  function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int k;
    logic signed [W-1:0] s;
    logic [W-1:0] r;
    k = int'(y[3:0]);
    s = x;
    if (!y[4]) r = x << k;
    else if (y[5]) r = s >>> k;
    else r = x >> k;
    case (op)
      4'b0001: return {1'b0, x + y};
      4'b0101: return {1'b0, x & y};
      4'b1001: return {1'b0, ~x};
      4'b1101: return {1'b0, r};
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction
  function automatic int lat_of(input logic [3:0] op, input logic [W-1:0] y);
    return (op == 4'b1101 && y[3:0] != 0) ? int'(y[3:0]) + 1 : 1;
  endfunction
  function automatic logic [2:0] nzp_of(input logic [W-1:0] v);
    return v[W-1] ? 3'b100 : (v == 0 ? 3'b010 : 3'b001);
  endfunction
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic ld, input int stall);
    @(negedge clk);
    r_acc_ok = in_ready;
    in_valid = 1'b1; opcode = op; a = x; b = y; ld_cc = ld; out_ready = 1'b0;
    @(posedge clk); #1;
    opcode = 4'($urandom); a = W'($urandom); b = W'($urandom); ld_cc = 1'($urandom); in_valid = 1'b0;
    r_lat = 0; r_ir_low = 1; r_hold = 1;
    do begin
      @(negedge clk);
      r_lat++;
      if (in_ready) r_ir_low = 0;
      if (!out_valid && (out !== prev_out || err !== prev_err)) r_hold = 0;
      in_valid = 1'($urandom);
    end while (!out_valid && r_lat < 100);
    r_tmo = !out_valid; r_out = out; r_err = err; r_nzp_pre = nzp; r_stable = 1;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom); opcode = 4'($urandom); a = W'($urandom);
      @(negedge clk);
      if (!out_valid || out !== r_out || err !== r_err || nzp !== r_nzp_pre) r_stable = 0;
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    r_nzp_post = nzp; r_post_ir = in_ready; r_post_ov = out_valid;
    in_valid = 1'b0; out_ready = 1'b0;
    prev_out = r_out; prev_err = r_err;
  endtask
  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ld_cc = 1'b0; opcode = '0; a = '0; b = '0;
    #1 rst = 1'b1;
    #1;
    n_chk++; if (out !== 0 || err !== 0 || out_valid !== 0) begin n_fail++; $display("FAIL reset_out out=%h err=%b ov=%b exp 0/0/0", out, err, out_valid); end
    n_chk++; if (nzp !== 3'b010 || in_ready !== 1) begin n_fail++; $display("FAIL reset_nzp nzp=%b ir=%b exp 010/1", nzp, in_ready); end
    @(negedge clk) rst = 1'b0;
    exp_nzp = 3'b010; prev_out = '0; prev_err = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_and;
    run_op(4'b0101, 16'h00F0, 16'h0F00, 1'b0, 0);
    n_chk++; if (r_out !== 16'h0000 || r_err !== 0) begin n_fail++; $display("FAIL and_out got %h/%b exp 0000/0", r_out, r_err); end
    n_chk++; if (r_lat !== 1) begin n_fail++; $display("FAIL and_lat got %0d exp 1", r_lat); end
    n_chk++; if (r_nzp_post !== 3'b010) begin n_fail++; $display("FAIL and_nzp got %b exp 010", r_nzp_post); end
  endtask
  task automatic test_add;
    run_op(4'b0001, 16'h7FFF, 16'h0001, 1'b1, 0);
    n_chk++; if (r_out !== 16'h8000) begin n_fail++; $display("FAIL add_out got %h exp 8000", r_out); end
    n_chk++; if (r_lat !== 1 || r_tmo) begin n_fail++; $display("FAIL add_lat got %0d exp 1", r_lat); end
    n_chk++; if (r_nzp_post !== 3'b100) begin n_fail++; $display("FAIL add_nzp got %b exp 100", r_nzp_post); end
    run_op(4'b0001, 16'hFFFF, 16'h0003, 1'b1, 0);
    n_chk++; if (r_out !== 16'h0002 || r_nzp_post !== 3'b001) begin n_fail++; $display("FAIL add_wrap got %h/%b exp 0002/001", r_out, r_nzp_post); end
    exp_nzp = 3'b001;
  endtask
  task automatic test_shift;
    logic [W-1:0] bs [4] = '{16'h0033, 16'h0013, 16'hFFC1, 16'h0022};
    logic [W:0] m;
    run_op(4'b1101, 16'h8001, 16'h0033, 1'b0, 0);
    n_chk++; if (r_out !== 16'hF000) begin n_fail++; $display("FAIL shr_arith got %h exp F000", r_out); end
    n_chk++; if (r_lat !== 4) begin n_fail++; $display("FAIL shr_lat got %0d exp 4", r_lat); end
    n_chk++; if (!r_ir_low || !r_hold) begin n_fail++; $display("FAIL shr_busy ir_low=%b hold=%b exp 1/1", r_ir_low, r_hold); end
    for (int i = 1; i < 4; i++) begin
      m = model(4'b1101, 16'h8001, bs[i]);
      run_op(4'b1101, 16'h8001, bs[i], 1'b0, 0);
      n_chk++; if (r_out !== m[W-1:0] || r_lat !== lat_of(4'b1101, bs[i])) begin n_fail++; $display("FAIL shift_%0d got %h lat %0d exp %h lat %0d", i, r_out, r_lat, m[W-1:0], lat_of(4'b1101, bs[i])); end
    end
    run_op(4'b1101, 16'h1234, 16'h0030, 1'b1, 0);
    n_chk++; if (r_out !== 16'h1234 || r_lat !== 1) begin n_fail++; $display("FAIL shift_zero got %h lat %0d exp 1234 lat 1", r_out, r_lat); end
    exp_nzp = 3'b001;
    n_chk++; if (r_nzp_post !== exp_nzp) begin n_fail++; $display("FAIL shift_nzp got %b exp %b", r_nzp_post, exp_nzp); end
  endtask
  task automatic test_stall;
    run_op(4'b0001, 16'h0000, 16'h0000, 1'b1, 0);
    n_chk++; if (r_nzp_post !== 3'b010) begin n_fail++; $display("FAIL stall_pre got %b exp 010", r_nzp_post); end
    run_op(4'b1001, 16'h0000, 16'h5555, 1'b1, 5);
    n_chk++; if (r_out !== 16'hFFFF || !r_stable) begin n_fail++; $display("FAIL stall_hold got %h stable=%b exp FFFF/1", r_out, r_stable); end
    n_chk++; if (r_nzp_pre !== 3'b010 || r_nzp_post !== 3'b100) begin n_fail++; $display("FAIL stall_nzp got %b->%b exp 010->100", r_nzp_pre, r_nzp_post); end
    n_chk++; if (!r_post_ir || r_post_ov) begin n_fail++; $display("FAIL stall_no_accept ir=%b ov=%b exp 1/0", r_post_ir, r_post_ov); end
    exp_nzp = 3'b100;
  endtask
  task automatic test_illegal;
    logic [3:0] ops [4] = '{4'b0000, 4'b0010, 4'b1111, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], W'($urandom), W'($urandom), 1'b1, i);
      n_chk++; if (r_out !== 0 || r_err !== 1 || r_lat !== 1) begin n_fail++; $display("FAIL illegal_%0d got %h err %b lat %0d exp 0000/1/1", i, r_out, r_err, r_lat); end
      n_chk++; if (r_nzp_post !== exp_nzp) begin n_fail++; $display("FAIL illegal_nzp_%0d got %b exp %b", i, r_nzp_post, exp_nzp); end
    end
  endtask
  task automatic test_random;
    logic [3:0] legal [4] = '{4'b0001, 4'b0101, 4'b1001, 4'b1101};
    logic [3:0] op;
    logic [W-1:0] x, y;
    logic ld;
    logic [W:0] m;
    int st;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 5) < 4 ? legal[$urandom_range(0, 3)] : 4'($urandom);
      x = W'($urandom); y = W'($urandom); ld = 1'($urandom); st = $urandom_range(0, 3);
      m = model(op, x, y);
      run_op(op, x, y, ld, st);
      if (ld && !m[W]) exp_nzp = nzp_of(m[W-1:0]);
      n_chk++; if (r_out !== m[W-1:0] || r_err !== m[W]) begin n_fail++; $display("FAIL rand_out op=%b a=%h b=%h got %h/%b exp %h/%b", op, x, y, r_out, r_err, m[W-1:0], m[W]); end
      n_chk++; if (r_tmo || r_lat !== lat_of(op, y) || !r_acc_ok) begin n_fail++; $display("FAIL rand_lat op=%b b=%h got %0d exp %0d acc=%b", op, y, r_lat, lat_of(op, y), r_acc_ok); end
      n_chk++; if (!r_hold || !r_stable || !r_ir_low) begin n_fail++; $display("FAIL rand_hold hold=%b stable=%b ir_low=%b exp 1/1/1", r_hold, r_stable, r_ir_low); end
      n_chk++; if (r_nzp_post !== exp_nzp) begin n_fail++; $display("FAIL rand_nzp got %b exp %b", r_nzp_post, exp_nzp); end
      n_chk++; if (!r_post_ir || r_post_ov) begin n_fail++; $display("FAIL rand_post ir=%b ov=%b exp 1/0", r_post_ir, r_post_ov); end
    end
  endtask
  task automatic test_reset_abort;
    bit seen;
    run_op(4'b0001, 16'h7000, 16'h1000, 1'b1, 0);
    n_chk++; if (r_nzp_post !== 3'b100) begin n_fail++; $display("FAIL abort_pre got %b exp 100", r_nzp_post); end
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'b1101; a = 16'hA5A5; b = 16'h000F; ld_cc = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (out_valid !== 0 || out !== 16'h8000) begin n_fail++; $display("FAIL abort_busy ov=%b out=%h exp 0/8000", out_valid, out); end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (out !== 0 || err !== 0 || out_valid !== 0 || nzp !== 3'b010 || in_ready !== 1) begin n_fail++; $display("FAIL abort_async out=%h err=%b ov=%b nzp=%b ir=%b exp 0/0/0/010/1", out, err, out_valid, nzp, in_ready); end
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen = 1; end
    out_ready = 1'b0;
    n_chk++; if (seen || nzp !== 3'b010) begin n_fail++; $display("FAIL abort_after ov_seen=%b nzp=%b exp 0/010", seen, nzp); end
    exp_nzp = 3'b010; prev_out = '0; prev_err = 1'b0;
    run_op(4'b1001, 16'h00FF, 16'h0000, 1'b1, 0);
    n_chk++; if (r_out !== 16'hFF00 || r_nzp_post !== 3'b100) begin n_fail++; $display("FAIL abort_resume got %h/%b exp FF00/100", r_out, r_nzp_post); end
  endtask
  initial begin
    test_reset;
    test_and;
    test_add;
    test_shift;
    test_stall;
    test_illegal;
    test_random;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
